// File: rtl/fetch_requester_pkg.sv
// Shared types and constants for the instruction fetch requester and its FIFO.
package fetch_requester_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned PC_WIDTH   = 32;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_requester_if.sv
// Memory-responder, redirect and instruction-consumer signals of the fetch requester.
interface fetch_requester_if;
  import fetch_requester_pkg::*;

  logic [PC_WIDTH-1:0]   memAddr;
  logic                  memIsRequest;
  logic [INST_WIDTH-1:0] memDout;
  logic                  memRequestDone;
  logic                  memReadValid;
  logic                  redirectValid;
  logic [PC_WIDTH-1:0]   redirectPc;
  logic [INST_WIDTH-1:0] instOut;
  logic [PC_WIDTH-1:0]   pcOut;
  logic                  instValid;
  logic                  instReady;

  modport master (
    output memAddr, memIsRequest, instOut, pcOut, instValid,
    input  memDout, memRequestDone, memReadValid, redirectValid, redirectPc, instReady
  );

  modport slave (
    input  memAddr, memIsRequest, instOut, pcOut, instValid,
    output memDout, memRequestDone, memReadValid, redirectValid, redirectPc, instReady
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small {pc,inst} FIFO with synchronous flush; push on a full FIFO is accepted only alongside a pop.
module fetch_fifo
  import fetch_requester_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetchEntry_t            din,
  output fetchEntry_t            dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetchEntry_t      mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign dout   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/fetch_requester.sv
// Sequential instruction fetcher: one outstanding memory request, results buffered in fetch_fifo,
// pipeline redirects flush the buffer and discard any in-flight response.
module fetch_requester
  import fetch_requester_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned         FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  fetch_requester_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetchState_t         state;
  logic [PC_WIDTH-1:0] fetchPc;
  logic [PC_WIDTH-1:0] seqPc;
  logic [PC_WIDTH-1:0] restartPc;
  fetchEntry_t         head;
  fetchEntry_t         pushEntry;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                fifoPush;
  logic                fifoPop;
  logic [CNT_W-1:0]    fifoCount;
  logic                respHit;
  logic                slotFree;
  logic                slotFreeAfterPush;

  assign respHit   = bus.memRequestDone && bus.memReadValid;
  assign fifoPop   = !fifoEmpty && bus.instReady;
  assign fifoPush  = (state == ST_WAIT) && respHit && !bus.redirectValid;
  assign pushEntry = {fetchPc, bus.memDout};
  assign seqPc     = fetchPc + PC_STEP;
  assign restartPc = bus.redirectValid ? bus.redirectPc : fetchPc;

  // A same-cycle pop counts as freeing a slot.
  assign slotFree          = !fifoFull || fifoPop;
  assign slotFreeAfterPush = fifoPop || (fifoCount < CNT_W'(FIFO_DEPTH - 1));

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifoPush),
    .pop   (fifoPop),
    .flush (bus.redirectValid),
    .din   (pushEntry),
    .dout  (head),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  assign bus.instValid = !fifoEmpty;
  assign bus.instOut   = head.inst;
  assign bus.pcOut     = head.pc;

  // memAddr is loaded on entry to ISSUE and then held until the next ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      fetchPc          <= RESET_PC;
      bus.memAddr      <= RESET_PC;
      bus.memIsRequest <= 1'b0;
    end else begin
      bus.memIsRequest <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.redirectValid) begin
            fetchPc          <= bus.redirectPc;
            bus.memAddr      <= bus.redirectPc;
            bus.memIsRequest <= 1'b1;
            state            <= ST_ISSUE;
          end else if (slotFree) begin
            bus.memAddr      <= fetchPc;
            bus.memIsRequest <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.redirectValid) begin
            fetchPc <= bus.redirectPc;
            state   <= ST_DRAIN;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.redirectValid) begin
            fetchPc <= bus.redirectPc;
            // Response landing with the redirect is the one being discarded.
            if (respHit) begin
              bus.memAddr      <= bus.redirectPc;
              bus.memIsRequest <= 1'b1;
              state            <= ST_ISSUE;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (respHit) begin
            fetchPc <= seqPc;
            if (slotFreeAfterPush) begin
              bus.memAddr      <= seqPc;
              bus.memIsRequest <= 1'b1;
              state            <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.redirectValid) fetchPc <= bus.redirectPc;
          if (respHit) begin
            bus.memAddr      <= restartPc;
            bus.memIsRequest <= 1'b1;
            state            <= ST_ISSUE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_requester.sv
// Self-checking bench for fetch_requester: cycle table after reset, scoreboard on delivered
// instructions, and directed backpressure / redirect / wrap / reset-abort sequences.
module tb_fetch_requester;
  import fetch_requester_pkg::*;

  typedef struct {
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInst;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  logic romRst;
  logic sbOn;
  int   nCmp  = 0;
  int   nFail = 0;

  fetchEntry_t sbQ[$];
  vec_t        vecs[10];

  fetch_requester_if bus ();
  fetch_requester_if bus2 ();

  fetch_requester #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  fetch_requester #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (bus2.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return 32'hDA7A_0000 | {16'h0000, a[17:2]};
  endfunction

  // ROM responders: capture a request, answer one cycle later for a single cycle.
  logic        pend1, resp1, pend2, resp2;
  logic [31:0] pendAddr1, respData1, pendAddr2, respData2;

  always @(posedge clk or posedge romRst) begin
    if (romRst) begin
      pend1 <= 1'b0; pendAddr1 <= '0; resp1 <= 1'b0; respData1 <= '0;
      pend2 <= 1'b0; pendAddr2 <= '0; resp2 <= 1'b0; respData2 <= '0;
    end else begin
      resp1 <= pend1; respData1 <= dataOf(pendAddr1);
      pend1 <= bus.memIsRequest; pendAddr1 <= bus.memAddr;
      resp2 <= pend2; respData2 <= dataOf(pendAddr2);
      pend2 <= bus2.memIsRequest; pendAddr2 <= bus2.memAddr;
    end
  end

  assign bus.memRequestDone  = resp1;
  assign bus.memReadValid    = resp1;
  assign bus.memDout         = respData1;
  assign bus2.memRequestDone = resp2;
  assign bus2.memReadValid   = resp2;
  assign bus2.memDout        = respData2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc);
    fetchEntry_t e;
    e.pc   = pc;
    e.inst = dataOf(pc);
    sbQ.push_back(e);
  endtask

  // Scoreboard: every accepted head entry must match the next expected one.
  always @(negedge clk) begin
    if (sbOn && bus.instValid && bus.instReady) begin
      nCmp++;
      if (sbQ.size() == 0) begin
        nFail++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h expected nothing", bus.pcOut, bus.instOut);
      end else begin
        fetchEntry_t e;
        e = sbQ.pop_front();
        if (bus.pcOut !== e.pc || bus.instOut !== e.inst) begin
          nFail++;
          $display("FAIL sb_entry: got pc=%h inst=%h expected pc=%h inst=%h",
                   bus.pcOut, bus.instOut, e.pc, e.inst);
        end
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.instReady = 1'b0;
    bus.redirectValid = 1'b0;
    repeat (4) @(posedge clk);
    sbQ.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitReq(input string name, input logic [31:0] addr);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.memIsRequest && n < 50);
    check({name, "_seen"}, 32'(bus.memIsRequest), 32'd1);
    check({name, "_addr"}, bus.memAddr, addr);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    int nReq;
    int nr;
    int no;
    logic [31:0] reqA[2];
    logic [31:0] outPc[2];
    logic [31:0] outInst[2];

    rst = 1'b1; rst2 = 1'b1; romRst = 1'b1; sbOn = 1'b1;
    bus.instReady = 1'b0; bus.redirectValid = 1'b0; bus.redirectPc = '0;
    bus2.instReady = 1'b0; bus2.redirectValid = 1'b0; bus2.redirectPc = '0;

    //        ready req addr          valid pc            inst
    vecs[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0, dataOf(32'h0)};
    vecs[4] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4, dataOf(32'h4)};
    vecs[7] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b1, 1'b0, 32'h8, 1'b0, 32'h0, 32'h0};
    vecs[9] = '{1'b1, 1'b1, 32'hC, 1'b1, 32'h8, dataOf(32'h8)};

    repeat (2) @(posedge clk);
    #1 romRst = 1'b0;

    // Reset values while rst is held
    @(negedge clk);
    check("rst_req",   32'(bus.memIsRequest), 32'd0);
    check("rst_addr",  bus.memAddr, 32'h0);
    check("rst_valid", 32'(bus.instValid), 32'd0);
    check("rst_inst",  bus.instOut, 32'h0);
    check("rst_pc",    bus.pcOut, 32'h0);

    // Streaming after reset release: one instruction every 3 cycles
    expect_entry(32'h0); expect_entry(32'h4); expect_entry(32'h8);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      bus.instReady = vecs[i].ready;
      @(negedge clk);
      check($sformatf("tbl%0d_req", i),   32'(bus.memIsRequest), 32'(vecs[i].expReq));
      check($sformatf("tbl%0d_addr", i),  bus.memAddr, vecs[i].expAddr);
      check($sformatf("tbl%0d_valid", i), 32'(bus.instValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        check($sformatf("tbl%0d_pc", i),   bus.pcOut, vecs[i].expPc);
        check($sformatf("tbl%0d_inst", i), bus.instOut, vecs[i].expInst);
      end
    end
    @(posedge clk); #1;
    bus.instReady = 1'b0;
    check("tbl_drain", 32'(sbQ.size()), 32'd0);

    // Backpressure: two entries buffered, fetcher parks in IDLE, resumes at pc 8
    doReset();
    nReq = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.memIsRequest) nReq++;
    end
    check("bp_req_count", 32'(nReq), 32'd2);
    check("bp_state", 32'(dut.state), 32'(ST_IDLE));
    check("bp_valid", 32'(bus.instValid), 32'd1);
    check("bp_head_pc", bus.pcOut, 32'h0);
    expect_entry(32'h0); expect_entry(32'h4); expect_entry(32'h8); expect_entry(32'hC);
    bus.instReady = 1'b1;
    waitReq("bp_resume", 32'h8);
    drain("bp_drain");
    bus.instReady = 1'b0;

    // Redirect during WAIT of pc 4: pc 4 discarded, fetch restarts at 0x20
    doReset();
    bus.instReady = 1'b1;
    expect_entry(32'h0); expect_entry(32'h20); expect_entry(32'h24);
    waitReq("rd_first", 32'h0);
    waitReq("rd_second", 32'h4);
    @(posedge clk); #1;
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'h20;
    @(posedge clk); #1;
    bus.redirectValid = 1'b0;
    waitReq("rd_target", 32'h20);
    drain("rd_drain");
    bus.instReady = 1'b0;

    // Redirect in the same cycle as a pop of a full FIFO
    doReset();
    repeat (20) @(posedge clk);
    #1;
    sbOn = 1'b0;
    bus.instReady = 1'b1;
    bus.redirectValid = 1'b1;
    bus.redirectPc = 32'h40;
    @(posedge clk); #1;
    bus.redirectValid = 1'b0;
    check("rdpop_valid", 32'(bus.instValid), 32'd0);
    check("rdpop_req", 32'(bus.memIsRequest), 32'd1);
    check("rdpop_addr", bus.memAddr, 32'h40);
    sbOn = 1'b1;
    expect_entry(32'h40); expect_entry(32'h44);
    drain("rdpop_drain");
    bus.instReady = 1'b0;

    // Reset mid-WAIT: the late response must not be captured
    doReset();
    bus.instReady = 1'b1;
    expect_entry(32'h0);
    waitReq("ra_first", 32'h0);
    waitReq("ra_second", 32'h4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
    expect_entry(32'h0); expect_entry(32'h4);
    waitReq("ra_restart", 32'h0);
    drain("ra_drain");
    bus.instReady = 1'b0;

    // Address wrap from RESET_PC 0xFFFFFFFC
    for (int i = 0; i < 2; i++) begin
      reqA[i] = 32'hDEAD_BEEF; outPc[i] = 32'hDEAD_BEEF; outInst[i] = 32'hDEAD_BEEF;
    end
    nr = 0; no = 0;
    bus2.instReady = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus2.memIsRequest && nr < 2) begin
        reqA[nr] = bus2.memAddr;
        nr++;
      end
      if (bus2.instValid && no < 2) begin
        outPc[no] = bus2.pcOut;
        outInst[no] = bus2.instOut;
        no++;
      end
    end
    check("wrap_req0", reqA[0], 32'hFFFF_FFFC);
    check("wrap_req1", reqA[1], 32'h0000_0000);
    check("wrap_pc0", outPc[0], 32'hFFFF_FFFC);
    check("wrap_inst0", outInst[0], dataOf(32'hFFFF_FFFC));
    check("wrap_pc1", outPc[1], 32'h0000_0000);
    check("wrap_inst1", outInst[1], dataOf(32'h0));
    rst2 = 1'b1;

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_requester.md
FETCH_REQUESTER -- requirements
Module: fetch_requester

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning number of buffered {pc,inst} entries (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 memAddr  output  32  fetch address presented to memory responder.
REQ-006 memIsRequest  output  1  request strobe to responder.
REQ-007 memDout  input  32  response data from responder.
REQ-008 memRequestDone  input  1  responder completion flag.
REQ-009 memReadValid  input  1  responder data-valid flag.
REQ-010 redirectValid  input  1  pipeline redirect (branch/jump) strobe.
REQ-011 redirectPc  input  32  redirect target, word-aligned.
REQ-012 instOut  output  32  head-of-FIFO instruction.
REQ-013 pcOut  output  32  address of instOut.
REQ-014 instValid  output  1  FIFO non-empty.
REQ-015 instReady  input  1  consumer accepts head entry when instValid && instReady.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, DRAIN; at most one request outstanding.
REQ-017 ISSUE: memIsRequest=1 for exactly one cycle, memAddr=fetchPc; next state WAIT (DRAIN if redirectValid same cycle).
REQ-018 WAIT/DRAIN: memIsRequest=0, memAddr held at issued address.
REQ-019 Response SHALL be accepted on the first WAIT/DRAIN cycle with memRequestDone && memReadValid, sampling memDout that cycle.
REQ-020 WAIT accept: push {fetchPc, memDout}, fetchPc += 4 (mod 2^32 wrap), next ISSUE if FIFO has >=1 free slot after push and pop of that cycle, else IDLE.
REQ-021 IDLE: go ISSUE on first cycle FIFO has a free slot (pop in same cycle counts as freeing).
REQ-022 redirectValid (any state): FIFO flushed same edge, fetchPc <= redirectPc; instValid low next cycle.
REQ-023 redirectValid in WAIT/ISSUE: go DRAIN; DRAIN accepts and discards the in-flight response, then ISSUE at fetchPc.
REQ-024 redirectValid in DRAIN: update fetchPc only; remain DRAIN; still exactly one response discarded.
REQ-025 redirectValid in IDLE: next state ISSUE.
REQ-026 Redirect has priority over push and pop in the same cycle; no popped or pushed entry survives.
REQ-027 Simultaneous push and pop on full FIFO SHALL be legal; count unchanged.
REQ-028 Minimum fetch period: 3 cycles per instruction (ISSUE, WAIT with 1-cycle responder latency, next ISSUE).
REQ-029 memRequestDone && memReadValid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-030 While rst high: state IDLE->ISSUE entry pending, fetchPc=RESET_PC, FIFO empty, memIsRequest=0, memAddr=RESET_PC, instValid=0, instOut=0, pcOut=0.
REQ-031 First ISSUE SHALL occur on the first posedge after rst deasserts; reset mid-WAIT abandons the transaction, its late response ignored per REQ-029.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, INST_WIDTH=32, PC_STEP=4.
REQ-033 FIFO SHALL be a sub-module fetch_fifo (sync push/pop/flush, async reset, full/empty/count).

Verification
REQ-034 Reset release, RESET_PC=0, ROM model 1-cycle latency, instReady=1 -> pcOut/instOut sequence 0/DATA0, 4/DATA1, 8/DATA2, one per 3 cycles.
REQ-035 instReady=0 -> exactly 2 entries (pc 0,4) buffered, FSM IDLE, memIsRequest stays 0; raise instReady -> fetch resumes at pc 8.
REQ-036 redirectValid with redirectPc=0x20 in WAIT of pc 4 -> pc 4 data discarded, next request addr 0x20, first output 0x20/DATA8.
REQ-037 Redirect same cycle as pop of full FIFO -> instValid 0 next cycle, no stale entry delivered.
REQ-038 RESET_PC=0xFFFFFFFC -> second fetch address 0x00000000 (wrap).
REQ-039 rst asserted during WAIT, response arrives after deassert -> response ignored, first output pc RESET_PC.
